// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers host payload and streams header, payload and parity to the router input port
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic        start,
  input  logic [1:0]  addr,
  input  logic        par_inj,
  output logic        ready,
  input  logic        busy,
  output logic [7:0]  d_out,
  output logic        pkt_valid,
  output logic        done,
  output logic        cmd_err,
  output logic [15:0] pkt_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PARITY, GAP} state_t;
  state_t state, state_n;
  logic [7:0] mem [0:63];
  logic [5:0] fill, rd_ptr, len;
  logic [7:0] par_acc;
  logic [15:0] gap_cnt;
  logic inj;
  logic wr, go, last;
  logic [5:0] fill_n;
  assign ready = state == IDLE;
  assign pl_ready = ready && fill != 6'd63;
  assign wr = pl_valid && pl_ready;
  assign fill_n = fill + 6'(wr);
  assign go = ready && start && fill_n != 6'd0;
  assign last = rd_ptr == len;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next-state: every wire step advances only on a non-busy edge
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? HDR : IDLE;
      HDR:     state_n = busy ? HDR : PAYLOAD;
      PAYLOAD: state_n = (!busy && last) ? PARITY : PAYLOAD;
      PARITY:  state_n = busy ? PARITY : GAP;
      GAP:     state_n = gap_cnt == 16'd1 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // payload storage, written only while idle
  always_ff @(posedge clk) if (wr) mem[fill] <= pl_data;
  // datapath: wire byte, parity accumulation, pointers, counters and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
      pkt_valid <= 1'b0;
      done <= 1'b0;
      cmd_err <= 1'b0;
      pkt_cnt <= '0;
      fill <= '0;
      rd_ptr <= '0;
      len <= '0;
      par_acc <= '0;
      gap_cnt <= '0;
      inj <= 1'b0;
    end else begin
      done <= 1'b0;
      cmd_err <= ready && start && fill_n == 6'd0;
      if (state == PARITY && !busy) fill <= '0;
      else if (wr) fill <= fill_n;
      case (state)
        IDLE: if (go) begin
          len <= fill_n;
          inj <= par_inj;
          d_out <= {fill_n, addr};
          par_acc <= {fill_n, addr};
          pkt_valid <= 1'b1;
        end
        HDR: if (!busy) begin
          d_out <= mem[0];
          rd_ptr <= 6'd1;
        end
        PAYLOAD: if (!busy) begin
          par_acc <= par_acc ^ d_out;
          if (last) begin
            d_out <= par_acc ^ d_out ^ {8{inj}};
            pkt_valid <= 1'b0;
          end else begin
            d_out <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
          end
        end
        PARITY: if (!busy) begin
          done <= 1'b1;
          pkt_cnt <= pkt_cnt + 16'd1;
          d_out <= '0;
          gap_cnt <= 16'(GAP_CYCLES);
        end
        GAP: gap_cnt <= gap_cnt - 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx
module tb_router_pkt_tx;
  localparam int GAP = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] pl_data = '0;
  logic pl_valid = 1'b0, start = 1'b0, par_inj = 1'b0, busy = 1'b0;
  logic [1:0] addr = '0;
  logic pl_ready, ready, pkt_valid, done, cmd_err;
  logic [7:0] d_out;
  logic [15:0] pkt_cnt;
  int checks = 0, errors = 0;
  logic [7:0] pay [0:63];
  int mfill = 0;
  logic bpat [0:127];

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .start(start), .addr(addr), .par_inj(par_inj), .ready(ready), .busy(busy),
    .d_out(d_out), .pkt_valid(pkt_valid), .done(done), .cmd_err(cmd_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      pl_valid = 1'b1;
      pl_data = base + 8'(i);
      checks++;
      if (pl_ready !== 1'(mfill < 63)) begin
        errors++;
        $display("FAIL load_ready byte %0d: got %b exp %b", i, pl_ready, mfill < 63);
      end
      if (mfill < 63) begin
        pay[mfill] = pl_data;
        mfill++;
      end
      tick();
    end
    pl_valid = 1'b0;
  endtask

  task automatic send_packet(input string name, input logic [1:0] a, input logic inj,
                             input int stall_i, input int stall_n);
    logic [7:0] seq [0:65];
    logic [7:0] p, exp_d;
    logic exp_v, exp_done;
    int n, pos;
    bit dn;
    n = mfill + 2;
    seq[0] = {6'(mfill), a};
    p = seq[0];
    for (int k = 0; k < mfill; k++) begin
      seq[k + 1] = pay[k];
      p ^= pay[k];
    end
    seq[n - 1] = p ^ (inj ? 8'hFF : 8'h00);
    for (int i = 0; i < 128; i++) bpat[i] = (i >= stall_i) && (i < stall_i + stall_n);
    addr = a;
    par_inj = inj;
    start = 1'b1;
    tick();
    start = 1'b0;
    pos = 0;
    dn = 0;
    for (int i = 0; i < n + stall_n + GAP + 2; i++) begin
      exp_d = pos < n ? seq[pos] : 8'h00;
      exp_v = pos < n - 1;
      exp_done = (pos == n) && !dn;
      checks++;
      if (d_out !== exp_d || pkt_valid !== exp_v || done !== exp_done) begin
        errors++;
        $display("FAIL %s cycle %0d: got d_out=%h pkt_valid=%b done=%b exp d_out=%h pkt_valid=%b done=%b",
                 name, i, d_out, pkt_valid, done, exp_d, exp_v, exp_done);
      end
      if (pos == n) dn = 1;
      busy = bpat[i];
      if (!bpat[i] && pos < n) pos++;
      tick();
    end
    busy = 1'b0;
    mfill = 0;
    checks++;
    if (ready !== 1'b1 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end_idle: got ready=%b pkt_valid=%b exp 1 0", name, ready, pkt_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (d_out !== 8'h00 || pkt_valid !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0 || pkt_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got d_out=%h pkt_valid=%b done=%b cmd_err=%b pkt_cnt=%h exp all 0",
               d_out, pkt_valid, done, cmd_err, pkt_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || pl_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got ready=%b pl_ready=%b exp 1 1", ready, pl_ready);
    end
  endtask

  task automatic test_basic;
    load_bytes(8, 8'h01);
    send_packet("basic", 2'd0, 1'b0, 200, 0);
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_pkt_cnt: got %0d exp 1", pkt_cnt);
    end
  endtask

  task automatic test_stall;
    load_bytes(8, 8'h01);
    send_packet("stall", 2'd0, 1'b0, 3, 3);
    checks++;
    if (pkt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_pkt_cnt: got %0d exp 2", pkt_cnt);
    end
  endtask

  task automatic test_par_inj;
    load_bytes(8, 8'h01);
    send_packet("par_inj", 2'd0, 1'b1, 200, 0);
    checks++;
    if (pkt_cnt !== 16'd3) begin
      errors++;
      $display("FAIL par_inj_pkt_cnt: got %0d exp 3", pkt_cnt);
    end
  endtask

  task automatic test_empty_start;
    addr = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (cmd_err !== 1'b1 || ready !== 1'b1 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_start: got cmd_err=%b ready=%b pkt_valid=%b exp 1 1 0", cmd_err, ready, pkt_valid);
    end
    tick();
    checks++;
    if (cmd_err !== 1'b0 || ready !== 1'b1 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_start_width: got cmd_err=%b ready=%b pkt_valid=%b exp 0 1 0", cmd_err, ready, pkt_valid);
    end
  endtask

  task automatic test_full;
    load_bytes(64, 8'h01);
    checks++;
    if (pl_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pl_ready: got %b exp 0", pl_ready);
    end
    send_packet("full", 2'd2, 1'b0, 10, 2);
    checks++;
    if (pkt_cnt !== 16'd4) begin
      errors++;
      $display("FAIL full_pkt_cnt: got %0d exp 4", pkt_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    bit saw_err;
    load_bytes(1, 8'hA5);
    mfill = 0;
    addr = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: got done=%b exp 1 within 20 cycles", done);
    end
    start = 1'b1;
    pl_valid = 1'b1;
    pl_data = 8'h3C;
    addr = 2'd3;
    cnt = 0;
    saw_err = 0;
    do begin
      tick();
      cnt++;
      if (cmd_err === 1'b1) saw_err = 1;
    end while (pkt_valid !== 1'b1 && cnt < 20);
    start = 1'b0;
    pl_valid = 1'b0;
    checks++;
    if (cnt != GAP + 1 || d_out !== 8'h07 || saw_err) begin
      errors++;
      $display("FAIL b2b_header: got gap=%0d d_out=%h cmd_err_seen=%b exp gap=%0d d_out=07 cmd_err_seen=0",
               cnt, d_out, saw_err, GAP + 1);
    end
    tick();
    checks++;
    if (d_out !== 8'h3C || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_payload: got d_out=%h pkt_valid=%b exp 3c 1", d_out, pkt_valid);
    end
    tick();
    checks++;
    if (d_out !== 8'h3B || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_parity: got d_out=%h pkt_valid=%b exp 3b 0", d_out, pkt_valid);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pkt_cnt !== 16'd6) begin
      errors++;
      $display("FAIL b2b_done: got done=%b pkt_cnt=%0d exp 1 6", done, pkt_cnt);
    end
    for (int i = 0; i < GAP + 1; i++) tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b exp 1", ready);
    end
  endtask

  task automatic test_mid_reset;
    bit saw_done;
    load_bytes(8, 8'h01);
    addr = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (d_out !== 8'h04 || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: got d_out=%h pkt_valid=%b exp 04 1", d_out, pkt_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pkt_valid !== 1'b0 || d_out !== 8'h00 || ready !== 1'b1 || pl_ready !== 1'b1 || pkt_cnt !== 16'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got pkt_valid=%b d_out=%h ready=%b pl_ready=%b pkt_cnt=%0d done=%b exp 0 00 1 1 0 0",
               pkt_valid, d_out, ready, pl_ready, pkt_cnt, done);
    end
    rst = 1'b0;
    mfill = 0;
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1 || pkt_valid === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset_quiet: got activity=1 exp 0");
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_emptied: got cmd_err=%b exp 1", cmd_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_par_inj();
    test_empty_start();
    test_full();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 1x3 router's input port. A host loads up to 63 payload bytes into an internal buffer, then issues a start with a destination address. The block then streams the header, payload and parity byte onto the router's `d_in`/`pkt_valid` interface, stalling on the router's `busy`. It sits upstream of the router and is the transmitter for the router's packet receiver.

## Interface
- `GAP_CYCLES`, default 2: idle cycles forced after each parity byte before the next header may be driven (min 1).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pl_data`  in  8  payload byte from host.
- `pl_valid`  in  1  host offers `pl_data`.
- `pl_ready`  out  1  buffer accepts a byte; = (state==IDLE) && (fill<63).
- `start`  in  1  single-cycle request to send the buffered packet.
- `addr`  in  2  destination port, sampled with `start`; 3 is legal (router treats it as invalid).
- `par_inj`  in  1  sampled with `start`; corrupts the parity byte (XOR 0xFF).
- `ready`  out  1  = (state==IDLE).
- `busy`  in  1  router busy; a byte is accepted only on an edge where `busy`=0.
- `d_out`  out  8  registered; connects to router `d_in`.
- `pkt_valid`  out  1  registered; connects to router `pkt_valid`.
- `done`  out  1  one-cycle pulse: parity byte accepted.
- `cmd_err`  out  1  one-cycle pulse: `start` with empty buffer.
- `pkt_cnt`  out  16  completed packets; wraps 0xFFFF->0.

## Operation
- Buffer: 64x8 storage, 6-bit `fill` write pointer and 6-bit `rd_ptr`. A write occurs on `pl_valid && pl_ready`. The buffer cannot be written outside IDLE.
- Packet format: header `{len[5:0], addr[1:0]}` with `len`=`fill`. It is followed by `len` payload bytes, then the parity byte. The parity byte is the XOR of the header and all payload bytes, XOR 0xFF if `par_inj`. `pkt_valid`=1 for the header and payload, and 0 while the parity byte is driven.
- FSM states and transitions:
  - IDLE: `d_out`=0, `pkt_valid`=0.
    - `start` with `fill_next`!=0: latch `addr`/`par_inj`/`len`, load `d_out`=header, `pkt_valid`=1, `par_acc`=header, go to HDR. `fill_next` includes a same-cycle write.
    - `start` with `fill_next`==0: pulse `cmd_err`, stay in IDLE.
  - HDR: hold the header. On an edge with `busy`=0: `d_out`=buf[0], `rd_ptr`=1, go to PAYLOAD.
  - PAYLOAD: hold `d_out`. On an edge with `busy`=0: `par_acc`^=`d_out`.
    - If `rd_ptr`==`len`: `d_out`=`par_acc`^`d_out`^(`par_inj`?0xFF:0), `pkt_valid`=0, go to PARITY.
    - Otherwise: `d_out`=buf[`rd_ptr`], `rd_ptr`++.
  - PARITY: hold. On an edge with `busy`=0: pulse `done`, `pkt_cnt`++, `fill`=0, `d_out`=0, load the gap counter, go to GAP.
  - GAP: count `GAP_CYCLES` cycles with `pkt_valid`=0, then go to IDLE.
- `start` outside IDLE is ignored with no error. `pl_valid` outside IDLE is not accepted.
- When `fill`==63, `pl_ready`=0; extra bytes are dropped by handshake.

## Timing
- Reset values: state IDLE, `d_out`=0, `pkt_valid`=0, `done`=0, `cmd_err`=0, `pkt_cnt`=0, `fill`=0, `rd_ptr`=0. `ready`=1 and `pl_ready`=1 from the first cycle after reset.
- A `rst` asserted mid-packet abandons the packet. `pkt_valid` is 0 after that edge and the buffer is emptied. Resetting the router alongside is the system's responsibility.
- Start seen at edge N: the header is on `d_out` from N.
- With `busy`=0 throughout:
  - payload byte k is on `d_out` from edge N+1+k;
  - the parity byte is on `d_out` from edge N+len+1;
  - `done` is high in the cycle after edge N+len+2.
  - Total on-wire length is len+2 cycles. The next header is no earlier than `GAP_CYCLES`+1 edges after `done`.
- `busy` stalls any state, including mid-payload and on the parity byte. `d_out`/`pkt_valid` are held stable; bytes are never skipped or duplicated.
- `done` and `cmd_err` are exactly one cycle wide.

## Test plan
- Load 01..08, start `addr`=0, `busy`=0 -> `d_out` is 0x20, 01..08 with `pkt_valid`=1 for 9 cycles, then 0x28 with `pkt_valid`=0. `done` pulses once; `pkt_cnt`=1.
- Same packet with `busy`=1 for 3 cycles while byte 03 is driven -> 03 is held 4 cycles; sequence and parity are unchanged (0x28).
- Same packet with `par_inj`=1 -> parity byte 0xD7; header and payload unchanged.
- `start` with an empty buffer -> `cmd_err` pulses 1 cycle, `ready` stays 1, `pkt_valid` stays 0.
- Offer 64 bytes -> 63 accepted, `pl_ready`=0 after the 63rd. Start `addr`=2 -> header 0xFE, 63 payload bytes, correct parity.
- Assert `rst` during payload byte 4 -> next cycle `pkt_valid`=0, `d_out`=0, `ready`=1, `pl_ready`=1, `pkt_cnt`=0, and `done` never pulses.
